dma_priority_resolver: RTL and testbench
========================================

// Module: dma_priority_resolver
// PURPOSE
//  Channel arbitration stage of the DMA controller. Sits between the DREQ pins and
//  the timing-and-control FSM. Resolves pending channel requests under fixed or
//  rotating priority, runs the HRQ/HLDA hold handshake with the CPU and drives DACK.
//  Its DACK output feeds timing-and-control and the protocol checker.
// PARAMETERS
//  NUM_CH   4   number of DMA channels; PTR_W = $clog2(NUM_CH)
// PORTS
//  CLK            in   1        system clock; all state changes on posedge
//  RESET_N        in   1        asynchronous reset, active-low
//  DREQ           in   NUM_CH   raw channel requests; synchronous to CLK
//  maskReg        in   NUM_CH   1 = channel masked (request ignored)
//  priorityType   in   1        0 = fixed (ch0 highest), 1 = rotating
//  dreqSenseLow   in   1        1 = DREQ active-low
//  dackSenseHigh  in   1        1 = DACK active-high
//  HLDA           in   1        hold acknowledge from CPU
//  serviceDone    in   1        1-cycle pulse from timing-and-control at end of service (S4)
//  HRQ            out  1        hold request to CPU
//  DACK           out  NUM_CH   channel acknowledge, polarity per dackSenseHigh
//  activeChannel  out  PTR_W    channel currently in service
//  channelValid   out  1        1 while activeChannel is valid (SERVICE state)
// BEHAVIOUR
//  - pend = (dreqSenseLow ? ~DREQ : DREQ) & ~maskReg; evaluated combinationally each cycle.
//  - Internal one-hot dackActive; DACK = dackSenseHigh ? dackActive : ~dackActive
//    (combinational polarity only).
//  - Reset (RESET_N=0, async): state=IDLE, HRQ=0, dackActive=0, activeChannel=0,
//    channelValid=0, priority pointer hiPtr=0 (ch0 highest).
//  - FSM states: IDLE, REQUEST, SERVICE.
//    IDLE: HRQ=0. If |pend, go to REQUEST; HRQ=1 from the next edge (1-cycle latency).
//    REQUEST: HRQ=1.
//      |pend==0 -> IDLE; HRQ drops the next cycle.
//      HLDA=1 && |pend -> latch the winner into activeChannel and go to SERVICE.
//        dackActive[winner] and channelValid are set at that same edge.
//      HLDA sampled high -> DACK active one cycle later.
//    SERVICE: HRQ=1, DACK held on the latched channel.
//      Deassertion of the channel's DREQ or a mask change does NOT end service.
//      serviceDone=1 -> IDLE. At that edge, dackActive=0 and channelValid=0.
//        If priorityType=1: hiPtr = (activeChannel+1) mod NUM_CH.
//      HLDA=0 (without serviceDone) -> abort to IDLE: DACK/channelValid cleared,
//        no rotation.
//      serviceDone and HLDA=0 in the same cycle -> treated as completion (rotation applies).
//  - Winner selection: first pend bit searched upward from start index s, wrapping
//    modulo NUM_CH. s = 0 if priorityType=0, s = hiPtr if priorityType=1.
//    hiPtr is retained but ignored while in fixed mode.
//  - One channel in service at most; at most one DACK bit active.
//    DACK never changes outside the REQUEST->SERVICE and SERVICE->IDLE edges.
//  - After SERVICE->IDLE, a still-pending request re-raises HRQ after one idle cycle
//    (HRQ low for at least one cycle between services).
//  - Reset mid-operation: immediate return to reset values, including hiPtr.
// TESTING
//  1 Fixed priority: DREQ=4'b0110, mask=0, HLDA tied 1
//    -> HRQ at +1, DACK=4'b0010 at +2, activeChannel=1.
//  2 Rotating: DREQ=4'b1111, serve ch0 then ch1 via serviceDone
//    -> DACK sequence 0001, 0010, 0100, 1000, then 0001.
//  3 Masking/sense: dreqSenseLow=1, DREQ=4'b1011, mask=4'b0100
//    -> no request, HRQ stays 0. Unmask -> DACK=4'b0100.
//  4 Request withdrawn: DREQ=4'b0001 for 1 cycle, HLDA=0
//    -> HRQ high for one cycle then 0; DACK never asserted.
//  5 HLDA drop: in SERVICE on ch2, HLDA->0 -> DACK cleared next edge;
//    rotating hiPtr unchanged (next winner from 4'b1111 is still ch2).
//  6 Async reset mid-SERVICE (dackSenseHigh=0)
//    -> DACK=4'b1111, HRQ=0, channelValid=0 immediately, without a clock edge.

Source files
------------

// File: rtl/dma_priority_resolver_if.sv
// ---------------------------------------------------------------------------
// dma_priority_resolver_if
//   Bundles the request/acknowledge and hold-handshake signals of the DMA
//   channel arbitration stage.
//   slave  : arbiter side (consumes DREQ/mask/config/HLDA/serviceDone,
//            produces HRQ/DACK/activeChannel/channelValid)
//   master : environment side (the opposite directions)
// ---------------------------------------------------------------------------
interface dma_priority_resolver_if #(
    parameter int NUM_CH = 4
);
    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] DREQ;
    logic [NUM_CH-1:0] maskReg;
    logic              priorityType;
    logic              dreqSenseLow;
    logic              dackSenseHigh;
    logic              HLDA;
    logic              serviceDone;
    logic              HRQ;
    logic [NUM_CH-1:0] DACK;
    logic [PTR_W-1:0]  activeChannel;
    logic              channelValid;

    modport slave (
        input  DREQ, maskReg, priorityType, dreqSenseLow, dackSenseHigh,
        input  HLDA, serviceDone,
        output HRQ, DACK, activeChannel, channelValid
    );

    modport master (
        output DREQ, maskReg, priorityType, dreqSenseLow, dackSenseHigh,
        output HLDA, serviceDone,
        input  HRQ, DACK, activeChannel, channelValid
    );
endinterface

// File: rtl/dma_priority_resolver.sv
// ---------------------------------------------------------------------------
// dma_priority_resolver
//   Channel arbitration stage of the DMA controller. Resolves pending DREQs
//   under fixed or rotating priority, runs the HRQ/HLDA hold handshake with
//   the CPU and drives a one-hot DACK for the channel in service.
// Ports
//   CLK      : system clock, all state changes on the rising edge
//   RESET_N  : asynchronous reset, active-low
//   bus      : slave side of dma_priority_resolver_if
//              in  DREQ, maskReg, priorityType, dreqSenseLow, dackSenseHigh,
//                  HLDA, serviceDone
//              out HRQ, DACK, activeChannel, channelValid
// ---------------------------------------------------------------------------
module dma_priority_resolver #(
    parameter int NUM_CH = 4
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    dma_priority_resolver_if.slave  bus
);
    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              hrq_q, hrq_d;
    logic [NUM_CH-1:0] dack_active_q, dack_active_d;
    logic [PTR_W-1:0]  active_ch_q, active_ch_d;
    logic              ch_valid_q, ch_valid_d;
    logic [PTR_W-1:0]  hi_ptr_q, hi_ptr_d;

    logic [NUM_CH-1:0] pend;
    logic              any_pend;
    logic [PTR_W-1:0]  start_idx;
    logic [PTR_W-1:0]  winner;
    logic              found;
    logic [PTR_W-1:0]  next_ptr;
    int                idx;

    assign pend     = (bus.dreqSenseLow ? ~bus.DREQ : bus.DREQ) & ~bus.maskReg;
    assign any_pend = |pend;

    // hiPtr is kept while in fixed mode but only steers the search when rotating.
    assign start_idx = bus.priorityType ? hi_ptr_q : '0;

    // First pending channel at or above start_idx, wrapping modulo NUM_CH.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = (int'(start_idx) + i) % NUM_CH;
            if (!found && pend[PTR_W'(idx)]) begin
                found  = 1'b1;
                winner = PTR_W'(idx);
            end
        end
    end

    assign next_ptr = (active_ch_q == PTR_W'(NUM_CH - 1)) ? '0 : active_ch_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        hrq_d         = hrq_q;
        dack_active_d = dack_active_q;
        active_ch_d   = active_ch_q;
        ch_valid_d    = ch_valid_q;
        hi_ptr_d      = hi_ptr_q;
        unique case (state_q)
            IDLE: begin
                hrq_d = 1'b0;
                if (any_pend) begin
                    state_d = REQUEST;
                    hrq_d   = 1'b1;
                end
            end
            REQUEST: begin
                if (!any_pend) begin
                    state_d = IDLE;
                    hrq_d   = 1'b0;
                end else if (bus.HLDA && found) begin
                    state_d       = SERVICE;
                    active_ch_d   = winner;
                    dack_active_d = NUM_CH'(1) << winner;
                    ch_valid_d    = 1'b1;
                end
            end
            SERVICE: begin
                // DREQ/mask changes are deliberately ignored here; only
                // completion or loss of the bus ends service. Completion wins
                // over a simultaneous HLDA drop so rotation still happens.
                if (bus.serviceDone) begin
                    state_d       = IDLE;
                    hrq_d         = 1'b0;
                    dack_active_d = '0;
                    ch_valid_d    = 1'b0;
                    if (bus.priorityType) begin
                        hi_ptr_d = next_ptr;
                    end
                end else if (!bus.HLDA) begin
                    state_d       = IDLE;
                    hrq_d         = 1'b0;
                    dack_active_d = '0;
                    ch_valid_d    = 1'b0;
                end
            end
            default: begin
                state_d       = IDLE;
                hrq_d         = 1'b0;
                dack_active_d = '0;
                ch_valid_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q       <= IDLE;
            hrq_q         <= 1'b0;
            dack_active_q <= '0;
            active_ch_q   <= '0;
            ch_valid_q    <= 1'b0;
            hi_ptr_q      <= '0;
        end else begin
            state_q       <= state_d;
            hrq_q         <= hrq_d;
            dack_active_q <= dack_active_d;
            active_ch_q   <= active_ch_d;
            ch_valid_q    <= ch_valid_d;
            hi_ptr_q      <= hi_ptr_d;
        end
    end

    assign bus.HRQ           = hrq_q;
    assign bus.DACK          = bus.dackSenseHigh ? dack_active_q : ~dack_active_q;
    assign bus.activeChannel = active_ch_q;
    assign bus.channelValid  = ch_valid_q;

endmodule

// File: tb/tb_dma_priority_resolver.sv
// ---------------------------------------------------------------------------
// tb_dma_priority_resolver
//   Directed scenarios followed by randomized traffic, compared against a
//   transaction-level reference model of the arbiter.
// ---------------------------------------------------------------------------
module tb_dma_priority_resolver;
    localparam int NUM_CH = 4;

    logic CLK;
    logic RESET_N;

    dma_priority_resolver_if #(.NUM_CH(NUM_CH)) bus ();

    dma_priority_resolver #(.NUM_CH(NUM_CH)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: granted channel (-1 = none), hold requested, rotation pointer.
    int m_grant;
    bit m_hold;
    int m_ptr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int pick(input logic [3:0] p, input int s);
        logic [1:0] k2;
        for (int k = 0; k < NUM_CH; k++) begin
            k2 = 2'((s + k) % NUM_CH);
            if (p[k2]) return (s + k) % NUM_CH;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_grant = -1;
        m_hold  = 1'b0;
        m_ptr   = 0;
    endtask

    task automatic model_step();
        logic [3:0] p;
        p = (bus.dreqSenseLow ? ~bus.DREQ : bus.DREQ) & ~bus.maskReg;
        if (m_grant >= 0) begin
            if (bus.serviceDone) begin
                if (bus.priorityType) m_ptr = (m_grant + 1) % NUM_CH;
                m_grant = -1;
                m_hold  = 1'b0;
            end else if (!bus.HLDA) begin
                m_grant = -1;
                m_hold  = 1'b0;
            end
        end else if (m_hold) begin
            if (p == 4'b0) m_hold = 1'b0;
            else if (bus.HLDA) m_grant = pick(p, bus.priorityType ? m_ptr : 0);
        end else if (p != 4'b0) begin
            m_hold = 1'b1;
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [3:0] d;
        d = (m_grant >= 0) ? 4'(1 << m_grant) : 4'b0;
        if (!bus.dackSenseHigh) d = ~d;
        chk({tag, "_hrq"},  32'(bus.HRQ),          32'(m_hold));
        chk({tag, "_dack"}, 32'(bus.DACK),         32'(d));
        chk({tag, "_cv"},   32'(bus.channelValid), 32'(m_grant >= 0));
        if (m_grant >= 0) chk({tag, "_ach"}, 32'(bus.activeChannel), 32'(m_grant));
    endtask

    task automatic cycle(input string tag);
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        check_outputs(tag);
    endtask

    logic [3:0] rot_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    initial begin
        RESET_N           = 1'b0;
        bus.DREQ          = '0;
        bus.maskReg       = '0;
        bus.priorityType  = 1'b0;
        bus.dreqSenseLow  = 1'b0;
        bus.dackSenseHigh = 1'b1;
        bus.HLDA          = 1'b0;
        bus.serviceDone   = 1'b0;
        model_reset();
        #12;
        chk("rst_hrq",  32'(bus.HRQ),          32'(1'b0));
        chk("rst_dack", 32'(bus.DACK),         32'(4'b0000));
        chk("rst_cv",   32'(bus.channelValid), 32'(1'b0));
        chk("rst_ach",  32'(bus.activeChannel), 32'(2'd0));
        @(negedge CLK);
        RESET_N = 1'b1;

        // Fixed priority, HLDA tied high.
        bus.DREQ = 4'b0110;
        bus.HLDA = 1'b1;
        cycle("t1a");
        chk("t1_hrq", 32'(bus.HRQ), 32'(1'b1));
        cycle("t1b");
        chk("t1_dack", 32'(bus.DACK), 32'(4'b0010));
        chk("t1_ach",  32'(bus.activeChannel), 32'(2'd1));
        bus.serviceDone = 1'b1;
        bus.DREQ        = 4'b0000;
        cycle("t1c");
        bus.serviceDone = 1'b0;
        cycle("t1d");

        // Rotating priority with all channels requesting.
        bus.priorityType = 1'b1;
        bus.DREQ         = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            cycle("t2r");
            cycle("t2s");
            chk("t2_dack", 32'(bus.DACK), 32'(rot_seq[i]));
            bus.serviceDone = 1'b1;
            cycle("t2d");
            bus.serviceDone = 1'b0;
        end
        bus.DREQ = 4'b0000;
        cycle("t2e");

        // Active-low sense with the only request masked, then unmasked.
        bus.priorityType = 1'b0;
        bus.dreqSenseLow = 1'b1;
        bus.DREQ         = 4'b1011;
        bus.maskReg      = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            cycle("t3m");
            chk("t3_hrq_masked", 32'(bus.HRQ), 32'(1'b0));
        end
        bus.maskReg = 4'b0000;
        cycle("t3u");
        cycle("t3s");
        chk("t3_dack", 32'(bus.DACK), 32'(4'b0100));
        bus.serviceDone  = 1'b1;
        bus.dreqSenseLow = 1'b0;
        bus.DREQ         = 4'b0000;
        cycle("t3d");
        bus.serviceDone = 1'b0;
        cycle("t3e");

        // Request withdrawn before HLDA.
        bus.HLDA = 1'b0;
        bus.DREQ = 4'b0001;
        cycle("t4a");
        chk("t4_hrq_hi", 32'(bus.HRQ), 32'(1'b1));
        bus.DREQ = 4'b0000;
        cycle("t4b");
        chk("t4_hrq_lo", 32'(bus.HRQ), 32'(1'b0));
        chk("t4_dack",   32'(bus.DACK), 32'(4'b0000));
        cycle("t4c");

        // HLDA drop during service leaves the rotation pointer alone.
        bus.priorityType = 1'b1;
        bus.HLDA         = 1'b1;
        bus.DREQ         = 4'b0010;
        cycle("t5a");
        cycle("t5b");
        bus.serviceDone = 1'b1;
        bus.DREQ        = 4'b0000;
        cycle("t5c");
        bus.serviceDone = 1'b0;
        bus.DREQ        = 4'b1111;
        cycle("t5d");
        cycle("t5e");
        chk("t5_dack_first", 32'(bus.DACK), 32'(4'b0100));
        bus.HLDA = 1'b0;
        cycle("t5f");
        chk("t5_dack_abort", 32'(bus.DACK), 32'(4'b0000));
        bus.HLDA = 1'b1;
        cycle("t5g");
        cycle("t5h");
        chk("t5_dack_again", 32'(bus.DACK), 32'(4'b0100));

        // Asynchronous reset while in service, active-low DACK.
        bus.dackSenseHigh = 1'b0;
        #1;
        chk("t6_dack_pre", 32'(bus.DACK), 32'(4'b1011));
        #1;
        RESET_N = 1'b0;
        #1;
        chk("t6_dack", 32'(bus.DACK),         32'(4'b1111));
        chk("t6_hrq",  32'(bus.HRQ),          32'(1'b0));
        chk("t6_cv",   32'(bus.channelValid), 32'(1'b0));
        model_reset();
        @(negedge CLK);
        RESET_N           = 1'b1;
        bus.dackSenseHigh = 1'b1;
        bus.DREQ          = 4'b0000;
        cycle("t6e");

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            bus.DREQ        = 4'($urandom);
            bus.maskReg     = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            bus.HLDA        = ($urandom_range(0, 7) != 0);
            bus.serviceDone = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) bus.priorityType  = ~bus.priorityType;
            if ($urandom_range(0, 31) == 0) bus.dreqSenseLow  = ~bus.dreqSenseLow;
            if ($urandom_range(0, 31) == 0) bus.dackSenseHigh = ~bus.dackSenseHigh;
            if (n == 200) begin
                #2;
                RESET_N = 1'b0;
                #1;
                model_reset();
                check_outputs("rnd_rst");
                @(negedge CLK);
                RESET_N = 1'b1;
            end
            cycle("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
